seg7_capture_decoder: RTL
=========================

# seg7_capture_decoder

Passive monitor that samples a time-multiplexed, active-low 7-segment display bus (segments plus digit selects) and turns each displayed glyph back into its 4-bit hex value. Each digit is stored in its own register. It lets the bench and on-chip debug logic read back what the display is showing without looking at CPU state. It sits beside the display driver on the board-facing side and only observes the bus.

## Interface
Parameters:
- NDIG, 4: number of multiplexed digits (2..8).
- STABLE, 4: cycles the segment and select inputs must stay unchanged before a capture (2..255).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- seg_n  in  [0:6]  segments, active-low; index 0 = a … index 6 = g.
- dig_sel_n  in  NDIG  digit enables, active-low; bit i selects digit i.
- clear  in  1  one-cycle pulse; clears all dig_valid bits and err.
- digits  out  4*NDIG  captured nibbles; digit i at [4i+3:4i].
- dig_valid  out  NDIG  digit i holds a successfully decoded value.
- err  out  1  sticky; an undecodable, non-blank pattern was captured.
- upd_stb  out  1  one-cycle pulse on every capture event.
- upd_idx  out  clog2(NDIG)  digit index of the latest capture; held between captures.

## Operation
- Inputs are registered once on entry. They are synchronous to clk; no synchronizer is used.
- A stability counter compares the registered {seg_n, dig_sel_n} with its value from the previous cycle:
  - any difference resets the counter to 0;
  - otherwise the counter increments, saturating at STABLE.
- States:
  - IDLE: no select low, or more than one select low. The counter is held at 0 and no capture occurs.
  - SETTLE: exactly one select low; counting toward STABLE.
  - HELD: capture done; waits for any input change, then goes back to SETTLE or IDLE.
- Each stable window produces exactly one capture, on the SETTLE→HELD transition.
- Glyph codes, written as active-high a..g (seg_n is the bitwise inverse):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1110011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Capture on selected digit i:
  - code matches a glyph: digits[i] ← nibble and dig_valid[i] ← 1;
  - blank (seg_n all ones): dig_valid[i] ← 0, digits[i] unchanged, err unchanged;
  - any other pattern: dig_valid[i] ← 0, digits[i] unchanged, err ← 1;
  - in all three cases upd_stb = 1 and upd_idx = i.
- clear and a capture in the same cycle:
  - the capture's effect on dig_valid[i] and err wins;
  - clear still applies to every other digit's valid bit.

## Timing
- Reset values: digits = 0, dig_valid = 0, err = 0, upd_stb = 0, upd_idx = 0, state IDLE, counter 0.
- Reset applied mid-SETTLE discards the pending capture.
- Capture latency: if the inputs change just before edge E0 and then stay constant, digits, dig_valid, err, upd_stb and upd_idx update at edge E0+STABLE+1.
- upd_stb is high for exactly one cycle per capture.
- Any input change before edge E0+STABLE+1 restarts the window; no partial capture is made.
- A held pattern never re-captures, however long it stays stable.
- clear acts at the next edge; dig_valid and err read 0 from then on unless a capture coincides with it.

## Structure
- Package seg7_pkg holds:
  - the 16 glyph constants SEG_GLYPH_0 … SEG_GLYPH_F (active-high a..g, index 0 = a);
  - SEG_BLANK;
  - the state enum {IDLE, SETTLE, HELD}.
- Sub-module seg7_pattern_decode: purely combinational.
  - Input: active-high 7-bit pattern.
  - Outputs: hit, blank, nibble[3:0].
  - Exhaustively unit-tested on its own.
- The top level holds the input register, the stability counter, the FSM and the per-digit storage.

## Test plan
- Default parameters; drive dig_sel_n=1110 with seg_n=~1111001 for 10 cycles -> at E0+5, digits[3:0]=3, dig_valid=0001, upd_stb for one cycle, upd_idx=0; no further strobe.
- Scan digits 0..3 showing F, d, 0, 8, 8 cycles each -> digits=0x80dF, dig_valid=1111, exactly 4 strobes with upd_idx 0,1,2,3.
- Hold seg_n=~1010101 on digit 2 -> err=1, dig_valid[2]=0, digits[11:8] unchanged; a later valid capture leaves err=1 until clear.
- Toggle seg_n every 3 cycles (STABLE=4), or drive dig_sel_n=1100 for 20 cycles -> no upd_stb, outputs unchanged.
- Pulse clear on the same edge as a digit 1 capture of 'A' -> dig_valid=0010, digits[7:4]=A, err=0.
- Drop rst_n for one cycle at E0+3 during a pending capture -> no strobe; all outputs 0; capture happens STABLE+1 cycles after reset release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table and FSM encoding for the 7-segment capture monitor.
// Glyphs are active-high a..g with index 0 = a (MSB of a [0:6] vector).
package seg7_pkg;

    localparam logic [0:6] SEG_GLYPH_0 = 7'b1111110;
    localparam logic [0:6] SEG_GLYPH_1 = 7'b0110000;
    localparam logic [0:6] SEG_GLYPH_2 = 7'b1101101;
    localparam logic [0:6] SEG_GLYPH_3 = 7'b1111001;
    localparam logic [0:6] SEG_GLYPH_4 = 7'b0110011;
    localparam logic [0:6] SEG_GLYPH_5 = 7'b1011011;
    localparam logic [0:6] SEG_GLYPH_6 = 7'b1011111;
    localparam logic [0:6] SEG_GLYPH_7 = 7'b1110000;
    localparam logic [0:6] SEG_GLYPH_8 = 7'b1111111;
    localparam logic [0:6] SEG_GLYPH_9 = 7'b1110011;
    localparam logic [0:6] SEG_GLYPH_A = 7'b1110111;
    localparam logic [0:6] SEG_GLYPH_B = 7'b0011111;
    localparam logic [0:6] SEG_GLYPH_C = 7'b1001110;
    localparam logic [0:6] SEG_GLYPH_D = 7'b0111101;
    localparam logic [0:6] SEG_GLYPH_E = 7'b1001111;
    localparam logic [0:6] SEG_GLYPH_F = 7'b1000111;
    localparam logic [0:6] SEG_BLANK   = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-high a..g pattern to its hex nibble; flags blank separately.
// Purely combinational, zero latency; no flow control.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [0:6] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        blank  = (pattern == SEG_BLANK);
        case (pattern)
            SEG_GLYPH_0: nibble = 4'h0;
            SEG_GLYPH_1: nibble = 4'h1;
            SEG_GLYPH_2: nibble = 4'h2;
            SEG_GLYPH_3: nibble = 4'h3;
            SEG_GLYPH_4: nibble = 4'h4;
            SEG_GLYPH_5: nibble = 4'h5;
            SEG_GLYPH_6: nibble = 4'h6;
            SEG_GLYPH_7: nibble = 4'h7;
            SEG_GLYPH_8: nibble = 4'h8;
            SEG_GLYPH_9: nibble = 4'h9;
            SEG_GLYPH_A: nibble = 4'hA;
            SEG_GLYPH_B: nibble = 4'hB;
            SEG_GLYPH_C: nibble = 4'hC;
            SEG_GLYPH_D: nibble = 4'hD;
            SEG_GLYPH_E: nibble = 4'hE;
            SEG_GLYPH_F: nibble = 4'hF;
            default:     hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Passive monitor of a multiplexed active-low 7-seg bus; stores the decoded nibble per digit.
// Capture lands STABLE+1 edges after the last input change; never backpressures (observe only).
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:6]              seg_n,
    input  logic [NDIG-1:0]         dig_sel_n,
    input  logic                    clear,
    output logic [4*NDIG-1:0]       digits,
    output logic [NDIG-1:0]         dig_valid,
    output logic                    err,
    output logic                    upd_stb,
    output logic [$clog2(NDIG)-1:0] upd_idx
);

    localparam int IW = $clog2(NDIG);

    logic [0:6]        seg_q, seg_d, seg_prev_q, seg_prev_d;
    logic [NDIG-1:0]   sel_q, sel_d, sel_prev_q, sel_prev_d;
    logic [7:0]        cnt_q, cnt_d;
    seg7_state_e       state_q, state_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic              err_q, err_d;
    logic              stb_q, stb_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic          same, onehot, capture;
    logic [IW-1:0] sel_idx;
    logic          dec_hit, dec_blank;
    logic [3:0]    dec_nibble;

    seg7_pattern_decode u_decode (
        .pattern (~seg_q),
        .hit     (dec_hit),
        .blank   (dec_blank),
        .nibble  (dec_nibble)
    );

    always_comb begin
        seg_d      = seg_n;
        sel_d      = dig_sel_n;
        seg_prev_d = seg_q;
        sel_prev_d = sel_q;
        same       = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
        onehot     = ($countones(~sel_q) == 1);
        sel_idx    = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!sel_q[i]) sel_idx = IW'(i);
        end
    end

    // A capture fires exactly once per window: when the counter reaches STABLE in SETTLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!onehot) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!same || state_q == IDLE) begin
            state_d = SETTLE;
            cnt_d   = '0;
        end else if (state_q == SETTLE) begin
            if (cnt_q < 8'(STABLE)) cnt_d = cnt_q + 8'd1;
            if (cnt_d == 8'(STABLE)) begin
                capture = 1'b1;
                state_d = HELD;
            end
        end
    end

    // Clear is applied first so a coincident capture overrides it for its own digit.
    always_comb begin
        digits_d = digits_q;
        valid_d  = clear ? '0 : valid_q;
        err_d    = clear ? 1'b0 : err_q;
        stb_d    = capture;
        idx_d    = idx_q;
        if (capture) begin
            idx_d = sel_idx;
            if (dec_hit) begin
                digits_d[{sel_idx, 2'b00} +: 4] = dec_nibble;
                valid_d[sel_idx]                = 1'b1;
            end else begin
                valid_d[sel_idx] = 1'b0;
                if (!dec_blank) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q      <= '1;
            sel_q      <= '1;
            seg_prev_q <= '1;
            sel_prev_q <= '1;
            cnt_q      <= '0;
            state_q    <= IDLE;
            digits_q   <= '0;
            valid_q    <= '0;
            err_q      <= 1'b0;
            stb_q      <= 1'b0;
            idx_q      <= '0;
        end else begin
            seg_q      <= seg_d;
            sel_q      <= sel_d;
            seg_prev_q <= seg_prev_d;
            sel_prev_q <= sel_prev_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            stb_q      <= stb_d;
            idx_q      <= idx_d;
        end
    end

    assign digits    = digits_q;
    assign dig_valid = valid_q;
    assign err       = err_q;
    assign upd_stb   = stb_q;
    assign upd_idx   = idx_q;

endmodule
